// File: rtl/m92_pkg.sv
// Shared M92 definitions: ROM sequencer states, default bank I/O port and the
// SDRAM byte base of the CPU program ROM region.
package m92_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FETCH  = 2'd2,
        DONE   = 2'd3
    } rom_seq_state_t;

    localparam logic [7:0]  M92_BANK_PORT    = 8'h20;
    localparam logic [24:0] M92_SDR_ROM_BASE = 25'h000000;

    // Word address to SDRAM byte address; the add wraps at 2^25 by width.
    function automatic logic [24:0] rom_sdr_addr(input logic [24:0] base,
                                                 input logic [18:0] word);
        return base + {5'd0, word, 1'b0};
    endfunction

endpackage

// File: rtl/m92_rom_word_buffer.sv
// One-entry ROM read buffer: 19-bit word tag, valid flag and 16-bit data,
// looked up combinationally and filled on a completed SDRAM fetch.
module m92_rom_word_buffer (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [18:0] lookup_tag,
    output logic        lookup_hit,
    output logic [15:0] lookup_data,
    input  logic        fill_en,
    input  logic [18:0] fill_tag,
    input  logic [15:0] fill_data
);

    logic        valid_q;
    logic [18:0] tag_q;
    logic [15:0] data_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only observed through valid_q.
    always_ff @(posedge clk_sys) begin
        if (fill_en) begin
            tag_q  <= fill_tag;
            data_q <= fill_data;
        end
    end

    assign lookup_hit  = valid_q && (tag_q == lookup_tag);
    assign lookup_data = data_q;

endmodule

// File: rtl/m92_rom_sequencer.sv
// M92 main-CPU program ROM sequencer: bank register, wait-state control and
// level req/ack fetches from the SDRAM ROM channel behind a one-word buffer.
module m92_rom_sequencer
    import m92_pkg::*;
#(
    parameter logic [7:0]  BANK_PORT = M92_BANK_PORT,
    parameter logic [24:0] ROM_BASE  = M92_SDR_ROM_BASE,
    parameter bit          BUF_EN    = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_cpu,
    input  logic        cpu_mreq,
    input  logic        cpu_rd,
    input  logic        cpu_rom_memrq,
    input  logic [19:0] rom_addr,
    input  logic        io_wr,
    input  logic [7:0]  io_addr,
    input  logic [7:0]  io_din,
    output logic [3:0]  bank_select,
    output logic        cpu_ready,
    output logic [15:0] cpu_rom_dout,
    output logic        sdr_req,
    output logic [24:0] sdr_addr,
    input  logic        sdr_ack,
    input  logic [15:0] sdr_data
);

    rom_seq_state_t state_q, state_d;
    logic [3:0]     bank_q, bank_d;
    logic           ready_q, ready_d;
    logic [15:0]    dout_q, dout_d;
    logic           req_q, req_d;
    logic [24:0]    addr_q, addr_d;
    logic [18:0]    word_q, word_d;
    logic           fill_en;
    logic           buf_hit;
    logic [15:0]    buf_data;
    logic           unused_bits;

    // Byte lane and the upper bank-port data bits carry no information here.
    assign unused_bits = ^{rom_addr[0], io_din[7:4]};

    m92_rom_word_buffer u_buf (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .lookup_tag  (word_q),
        .lookup_hit  (buf_hit),
        .lookup_data (buf_data),
        .fill_en     (fill_en),
        .fill_tag    (word_q),
        .fill_data   (sdr_data)
    );

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        ready_d = ready_q;
        dout_d  = dout_q;
        req_d   = req_q;
        addr_d  = addr_q;
        word_d  = word_q;
        fill_en = 1'b0;

        if (ce_cpu && io_wr && (io_addr == BANK_PORT)) begin
            bank_d = io_din[3:0];
        end

        case (state_q)
            IDLE: begin
                if (ce_cpu && cpu_mreq && cpu_rom_memrq && cpu_rd) begin
                    word_d  = rom_addr[19:1];
                    ready_d = 1'b0;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (BUF_EN && buf_hit) begin
                    dout_d  = buf_data;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    req_d   = 1'b1;
                    addr_d  = rom_sdr_addr(ROM_BASE, word_q);
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Waits on the SDRAM, not the CPU, so ce_cpu is not required.
                if (sdr_ack) begin
                    dout_d  = sdr_data;
                    fill_en = 1'b1;
                    req_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ce_cpu) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            bank_q  <= 4'd0;
            ready_q <= 1'b1;
            dout_q  <= 16'd0;
            req_q   <= 1'b0;
            addr_q  <= 25'd0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            ready_q <= ready_d;
            dout_q  <= dout_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        word_q <= word_d;
    end

    assign bank_select  = bank_q;
    assign cpu_ready    = ready_q;
    assign cpu_rom_dout = dout_q;
    assign sdr_req      = req_q;
    assign sdr_addr     = addr_q;

endmodule

// File: tb/tb_m92_rom_sequencer.sv
// Self-checking bench for m92_rom_sequencer: directed scenarios followed by a
// randomized mix, checked against a transaction-level model of the sequencer.
module tb_m92_rom_sequencer;

    localparam longint MAIN_BASE  = 0;
    localparam longint NOBUF_BASE = 25'h1FFFF00;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_cpu;
    logic        cpu_mreq, cpu_rd, cpu_rom_memrq;
    logic [19:0] rom_addr;
    logic        io_wr;
    logic [7:0]  io_addr, io_din;
    logic [3:0]  bank_select;
    logic        cpu_ready;
    logic [15:0] cpu_rom_dout;
    logic        sdr_req;
    logic [24:0] sdr_addr;
    logic        sdr_ack;
    logic [15:0] sdr_data;

    logic        mreq_b, ack_b;
    logic [19:0] rom_addr_b;
    logic [15:0] data_b;
    logic [3:0]  bank_b;
    logic        ready_b, req_b;
    logic [15:0] dout_b;
    logic [24:0] addr_b;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model state
    bit          m_valid;
    logic [18:0] m_tag;
    logic [15:0] m_data;
    logic [3:0]  m_bank;
    logic [15:0] m_dout;

    always #5 clk_sys = ~clk_sys;

    m92_rom_sequencer u_dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ce_cpu        (ce_cpu),
        .cpu_mreq      (cpu_mreq),
        .cpu_rd        (cpu_rd),
        .cpu_rom_memrq (cpu_rom_memrq),
        .rom_addr      (rom_addr),
        .io_wr         (io_wr),
        .io_addr       (io_addr),
        .io_din        (io_din),
        .bank_select   (bank_select),
        .cpu_ready     (cpu_ready),
        .cpu_rom_dout  (cpu_rom_dout),
        .sdr_req       (sdr_req),
        .sdr_addr      (sdr_addr),
        .sdr_ack       (sdr_ack),
        .sdr_data      (sdr_data)
    );

    m92_rom_sequencer #(
        .BANK_PORT (8'h20),
        .ROM_BASE  (25'h1FFFF00),
        .BUF_EN    (1'b0)
    ) u_nobuf (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ce_cpu        (ce_cpu),
        .cpu_mreq      (mreq_b),
        .cpu_rd        (1'b1),
        .cpu_rom_memrq (1'b1),
        .rom_addr      (rom_addr_b),
        .io_wr         (1'b0),
        .io_addr       (8'h00),
        .io_din        (8'h00),
        .bank_select   (bank_b),
        .cpu_ready     (ready_b),
        .cpu_rom_dout  (dout_b),
        .sdr_req       (req_b),
        .sdr_addr      (addr_b),
        .sdr_ack       (ack_b),
        .sdr_data      (data_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [24:0] exp_sdr(input longint base, input logic [19:0] a);
        longint t;
        t = (base + 2 * longint'(a >> 1)) % 33554432;
        return t[24:0];
    endfunction

    task automatic do_read(input logic [19:0] a, input int delay, input logic [15:0] d);
        bit hit;
        logic [24:0] ea;
        hit = m_valid && (m_tag == a[19:1]);
        ea  = exp_sdr(MAIN_BASE, a);
        cpu_mreq = 1'b1; cpu_rd = 1'b1; cpu_rom_memrq = 1'b1; rom_addr = a;
        tick();
        cpu_mreq = 1'b0; cpu_rom_memrq = 1'b0;
        chk("lookup_ready", cpu_ready, 0);
        chk("lookup_req", sdr_req, 0);
        tick();
        if (hit) begin
            chk("hit_ready", cpu_ready, 1);
            chk("hit_req", sdr_req, 0);
            chk("hit_dout", cpu_rom_dout, m_data);
            m_dout = m_data;
        end else begin
            chk("miss_req", sdr_req, 1);
            chk("miss_addr", sdr_addr, ea);
            chk("miss_ready", cpu_ready, 0);
            for (int i = 0; i < delay; i++) begin
                tick();
                chk("wait_req", sdr_req, 1);
                chk("wait_addr", sdr_addr, ea);
                chk("wait_ready", cpu_ready, 0);
            end
            sdr_ack = 1'b1; sdr_data = d;
            tick();
            sdr_ack = 1'b0; sdr_data = $urandom;
            chk("ack_req", sdr_req, 0);
            chk("ack_ready", cpu_ready, 1);
            chk("ack_dout", cpu_rom_dout, d);
            m_valid = 1'b1; m_tag = a[19:1]; m_data = d; m_dout = d;
        end
        tick();
        chk("done_ready", cpu_ready, 1);
        chk("done_dout", cpu_rom_dout, m_dout);
    endtask

    task automatic do_bank(input logic [7:0] port, input logic [7:0] din, input logic ce);
        io_wr = 1'b1; io_addr = port; io_din = din; ce_cpu = ce;
        tick();
        io_wr = 1'b0; ce_cpu = 1'b1;
        if (ce && port == 8'h20) m_bank = din[3:0];
        chk("bank", bank_select, m_bank);
        chk("bank_ready", cpu_ready, 1);
    endtask

    // ROM writes, non-ROM cycles and strobes without ce must not stall or fetch.
    task automatic do_nofetch(input logic rom, input logic rd, input logic ce);
        cpu_mreq = 1'b1; cpu_rom_memrq = rom; cpu_rd = rd; ce_cpu = ce;
        rom_addr = 20'($urandom);
        tick();
        cpu_mreq = 1'b0; cpu_rom_memrq = 1'b0; ce_cpu = 1'b1;
        chk("nf_ready", cpu_ready, 1);
        chk("nf_req", sdr_req, 0);
        tick();
        chk("nf_ready2", cpu_ready, 1);
        chk("nf_req2", sdr_req, 0);
        chk("nf_dout", cpu_rom_dout, m_dout);
    endtask

    task automatic do_reset_in_fetch(input logic [19:0] a0);
        logic [19:0] a;
        a = a0;
        if (m_valid && m_tag == a[19:1]) a = a ^ 20'h00002;
        cpu_mreq = 1'b1; cpu_rd = 1'b1; cpu_rom_memrq = 1'b1; rom_addr = a;
        tick();
        cpu_mreq = 1'b0; cpu_rom_memrq = 1'b0;
        tick();
        chk("rf_req", sdr_req, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_valid = 1'b0; m_bank = 4'd0; m_dout = 16'd0;
        chk("rf_req_drop", sdr_req, 0);
        chk("rf_ready", cpu_ready, 1);
        chk("rf_dout", cpu_rom_dout, 0);
        chk("rf_bank", bank_select, 0);
        sdr_ack = 1'b1; sdr_data = 16'hBEEF;
        tick();
        sdr_ack = 1'b0;
        chk("stale_req", sdr_req, 0);
        chk("stale_dout", cpu_rom_dout, 0);
        chk("stale_ready", cpu_ready, 1);
    endtask

    initial begin
        logic [19:0] pool [4];
        pool[0] = 20'h00100; pool[1] = 20'h00102; pool[2] = 20'h70000; pool[3] = 20'hFFFFE;

        reset = 1'b1; ce_cpu = 1'b1; cpu_mreq = 1'b0; cpu_rd = 1'b0; cpu_rom_memrq = 1'b0;
        rom_addr = '0; io_wr = 1'b0; io_addr = '0; io_din = '0; sdr_ack = 1'b0; sdr_data = '0;
        mreq_b = 1'b0; ack_b = 1'b0; rom_addr_b = 20'h00180; data_b = '0;
        m_valid = 1'b0; m_tag = '0; m_data = '0; m_bank = '0; m_dout = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_bank", bank_select, 0);
        chk("rst_ready", cpu_ready, 1);
        chk("rst_dout", cpu_rom_dout, 0);
        chk("rst_req", sdr_req, 0);
        chk("rst_addr", sdr_addr, 0);

        do_read(20'h00100, 5, 16'h1234);
        do_read(20'h00101, 0, 16'h0000);
        chk("repeat_dout", cpu_rom_dout, 16'h1234);
        do_bank(8'h20, 8'h37, 1'b1);
        chk("bank_7", bank_select, 4'd7);
        do_read(20'h70000, 2, 16'h5A5A);
        do_nofetch(1'b1, 1'b0, 1'b1);
        do_nofetch(1'b0, 1'b1, 1'b1);
        do_nofetch(1'b1, 1'b1, 1'b0);
        do_bank(8'h20, 8'h0C, 1'b0);
        do_bank(8'h21, 8'h0C, 1'b1);
        do_reset_in_fetch(20'h00100);
        do_read(20'h70000, 1, 16'hC0DE);

        for (int it = 0; it < 80; it++) begin
            int op;
            op = $urandom_range(0, 11);
            if (op <= 5)       do_read(pool[$urandom_range(0, 3)], $urandom_range(0, 4), 16'($urandom));
            else if (op == 6)  do_read(20'($urandom), $urandom_range(0, 3), 16'($urandom));
            else if (op == 7)  do_bank($urandom_range(0, 1) ? 8'h20 : 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
            else if (op == 8)  do_nofetch(1'b1, 1'b0, 1'b1);
            else if (op == 9)  do_nofetch(1'b0, 1'b1, 1'b1);
            else if (op == 10) do_nofetch(1'b1, 1'b1, 1'b0);
            else               do_reset_in_fetch(pool[$urandom_range(0, 3)]);
        end

        // Without the buffer, repeated reads of one word always fetch; base add wraps.
        for (int k = 0; k < 2; k++) begin
            mreq_b = 1'b1;
            tick();
            mreq_b = 1'b0;
            tick();
            chk("nobuf_req", req_b, 1);
            chk("nobuf_addr", addr_b, exp_sdr(NOBUF_BASE, rom_addr_b));
            ack_b = 1'b1; data_b = 16'hA5A0 + 16'(k);
            tick();
            ack_b = 1'b0;
            chk("nobuf_ready", ready_b, 1);
            chk("nobuf_dout", dout_b, 16'hA5A0 + 16'(k));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/m92_rom_sequencer.md
Name: m92_rom_sequencer

Overview:
Sequences CPU program-ROM reads for the M92 main CPU. It owns the ROM bank-select register. It takes the decoded ROM request and translated ROM address from the address decoder. It issues level req/ack fetches to the shared SDRAM ROM port and holds the CPU in wait until data returns. A one-entry read buffer removes repeat fetches of the same word. The block sits between the CPU bus, the address decoder and the SDRAM controller's CPU-ROM channel.

Parameters:
BANK_PORT, 8'h20, I/O port address whose write loads bank_select.
ROM_BASE, 25'h000000, SDRAM byte base added to the translated ROM address.
BUF_EN, 1, 1 enables the one-entry read buffer; 0 makes every read a miss.

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
ce_cpu  in  1  CPU clock enable; CPU-side strobes are valid only when high
cpu_mreq  in  1  one-ce pulse marking the start of a memory cycle
cpu_rd  in  1  1 = read cycle, 0 = write cycle
cpu_rom_memrq  in  1  decoder: the current address is ROM
rom_addr  in  20  decoder: translated ROM byte address
io_wr  in  1  one-ce pulse marking an I/O write
io_addr  in  8  I/O port address
io_din  in  8  I/O write data
bank_select  out  4  ROM bank register, fed to the decoder
cpu_ready  out  1  0 = insert wait state
cpu_rom_dout  out  16  ROM read data, valid while cpu_ready=1 after a ROM read
sdr_req  out  1  fetch request, level
sdr_addr  out  25  SDRAM byte address, bit 0 always 0
sdr_ack  in  1  one-cycle pulse; sdr_data is valid in the same cycle
sdr_data  in  16  fetched word

Behaviour:
- Reset values:
  - bank_select=0, cpu_ready=1, cpu_rom_dout=0, sdr_req=0, sdr_addr=0.
  - Buffer valid=0, state=IDLE.
  - Reset asserted mid-fetch drops sdr_req on the next edge. Any late sdr_ack received after reset is ignored.
- Bank register: io_wr & ce_cpu & io_addr==BANK_PORT loads bank_select <= io_din[3:0]. Effect is visible to the decoder the next cycle. It never stalls the CPU.
- State machine (states IDLE, LOOKUP, FETCH, DONE); all CPU-side transitions are qualified by ce_cpu except FETCH.
  - IDLE: on cpu_mreq & cpu_rom_memrq & cpu_rd:
    - latch word address {rom_addr[19:1]}, drop cpu_ready, go to LOOKUP.
    - ROM writes (cpu_rd=0) and non-ROM cycles leave cpu_ready=1 and the state in IDLE. ROM writes are discarded.
  - LOOKUP, one clk_sys cycle:
    - If BUF_EN & buffer valid & tag==latched word address: drive cpu_rom_dout from the buffer and go to DONE. A hit is ready 2 clk_sys cycles after mreq.
    - Otherwise assert sdr_req with sdr_addr=ROM_BASE+{latched[19:1],1'b0} and go to FETCH.
  - FETCH: hold sdr_req and sdr_addr stable. On sdr_ack:
    - capture sdr_data into cpu_rom_dout and the buffer; set tag and valid.
    - drop sdr_req the same edge, go to DONE.
    - sdr_ack outside FETCH is ignored.
  - DONE: cpu_ready=1. cpu_rom_dout holds its value until the next ROM read completes. Return to IDLE on the next ce_cpu.
- A cpu_mreq while not in IDLE is ignored; the CPU cannot issue one while stalled.
- Address arithmetic: the 25-bit ROM_BASE add wraps modulo 2^25.
- The buffer is not invalidated by bank writes because its tag is the translated address.

Decomposition:
- m92_pkg holds:
  - the rom_seq_state_t enum (IDLE, LOOKUP, FETCH, DONE)
  - the localparam for the default bank port
  - the SDRAM base constant, shared with the SDRAM region map.
- Optional sub-module m92_rom_word_buffer: 19-bit tag, valid flag and 16-bit data, with lookup and fill ports.

Test Plan:
- Reset, then ROM read of 0x00100: sdr_req high with sdr_addr=0x000100. Ack with data 0x1234 after 5 cycles, then cpu_ready=1 and cpu_rom_dout=0x1234.
- Immediate repeat read of 0x00101: no sdr_req, cpu_ready returns 2 cycles after mreq, data=0x1234.
- io_wr port 0x20 data 0x37: bank_select=7 next cycle. A read of 0xA0000 with the decoder giving rom_addr=0x70000 fetches sdr_addr=0x070000.
- ROM write and a read of 0xE0000 (RAM): cpu_ready stays 1 and sdr_req stays 0.
- Reset asserted in FETCH, then a stale sdr_ack: sdr_req=0 next cycle, buffer invalid, cpu_rom_dout=0, and the next read of the same address misses.
- BUF_EN=0: two reads of the same address both issue sdr_req.
